// File: rtl/rob_buffer.sv
// ---------------------------------------------------------------------------
// rob_buffer
// 8-entry circular reorder buffer. Hands out tags at dispatch, captures CDB
// results, retires completed entries to the register file in program order,
// and offers two combinational operand-lookup ports with a CDB bypass.
//
// Ports
//   clk1, rst                  clock (rising edge), async active-high reset
//   alloc_valid/alloc_rd       dispatch request and its destination register
//   alloc_ready/alloc_idx      entry available / tag granted (tail pointer)
//   cdb_valid/cdb_idx/cdb_value  result broadcast
//   commit_valid/rd/value      head entry offered for retirement
//   commit_ready               register file accepts the commit
//   flush                      synchronous squash of all entries
//   srcN_idx/srcN_done/srcN_value  operand lookup ports (N = 1, 2)
//   count/empty/full           occupancy status
// ---------------------------------------------------------------------------
module rob_buffer #(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3,
  parameter int DATA_W = 16,
  parameter int REG_W  = 5
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_rd,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_idx,
  input  logic              cdb_valid,
  input  logic [IDX_W-1:0]  cdb_idx,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              commit_valid,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_value,
  input  logic              commit_ready,
  input  logic              flush,
  input  logic [IDX_W-1:0]  src1_idx,
  output logic              src1_done,
  output logic [DATA_W-1:0] src1_value,
  input  logic [IDX_W-1:0]  src2_idx,
  output logic              src2_done,
  output logic [DATA_W-1:0] src2_value,
  output logic [IDX_W:0]    count,
  output logic              empty,
  output logic              full
);

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [REG_W-1:0]  rd_q    [DEPTH];
  logic [REG_W-1:0]  rd_d    [DEPTH];
  logic [DATA_W-1:0] value_q [DEPTH];
  logic [DATA_W-1:0] value_d [DEPTH];
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [IDX_W:0]    count_q, count_d;

  logic alloc_fire;
  logic commit_fire;
  logic cdb_hit;

  // Per-entry one-hot strobes for the three update sources.
  logic [DEPTH-1:0] alloc_sel;
  logic [DEPTH-1:0] cdb_sel;
  logic [DEPTH-1:0] commit_sel;

  // Status comes from registered count only, so a same-cycle commit never
  // opens a slot for an allocation while full.
  assign full        = (count_q == (IDX_W+1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign alloc_ready = !full;
  assign alloc_idx   = tail_q;

  assign commit_valid = busy_q[head_q] && done_q[head_q];
  assign commit_rd    = commit_valid ? rd_q[head_q]    : '0;
  assign commit_value = commit_valid ? value_q[head_q] : '0;

  assign alloc_fire  = alloc_valid && !full;
  assign commit_fire = commit_valid && commit_ready;
  // A broadcast only lands on an entry that is already busy; an entry being
  // allocated in the same cycle is not yet busy and so ignores it.
  assign cdb_hit     = cdb_valid && busy_q[cdb_idx];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
      assign alloc_sel[gi]  = alloc_fire  && (tail_q  == IDX_W'(gi));
      assign cdb_sel[gi]    = cdb_hit     && (cdb_idx == IDX_W'(gi));
      assign commit_sel[gi] = commit_fire && (head_q  == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    busy_d  = busy_q;
    done_d  = done_q;
    rd_d    = rd_q;
    value_d = value_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (flush) begin
      // Squash everything; payload fields are left as-is since they are
      // masked whenever the entry is not busy.
      busy_d  = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_sel[i]) begin
          busy_d[i] = 1'b1;
          done_d[i] = 1'b0;
          rd_d[i]   = alloc_rd;
        end
        if (cdb_sel[i]) begin
          done_d[i]  = 1'b1;
          value_d[i] = cdb_value;
        end
        // Retirement frees the slot last so it wins over a late broadcast.
        if (commit_sel[i]) begin
          busy_d[i] = 1'b0;
          done_d[i] = 1'b0;
        end
      end
      if (alloc_fire)  tail_d = tail_q + 1'b1;
      if (commit_fire) head_d = head_q + 1'b1;
      case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]    <= '0;
        value_q[i] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]    <= rd_d[i];
        value_q[i] <= value_d[i];
      end
    end
  end

  // Operand lookup: a matching broadcast this cycle is forwarded directly,
  // otherwise the stored entry state is reported. Free entries read as zero.
  always_comb begin
    src1_done  = 1'b0;
    src1_value = '0;
    if (busy_q[src1_idx]) begin
      if (cdb_valid && (cdb_idx == src1_idx)) begin
        src1_done  = 1'b1;
        src1_value = cdb_value;
      end else begin
        src1_done  = done_q[src1_idx];
        src1_value = value_q[src1_idx];
      end
    end
  end

  always_comb begin
    src2_done  = 1'b0;
    src2_value = '0;
    if (busy_q[src2_idx]) begin
      if (cdb_valid && (cdb_idx == src2_idx)) begin
        src2_done  = 1'b1;
        src2_value = cdb_value;
      end else begin
        src2_done  = done_q[src2_idx];
        src2_value = value_q[src2_idx];
      end
    end
  end

endmodule

// File: tb/tb_rob_buffer.sv
// ---------------------------------------------------------------------------
// tb_rob_buffer
// Directed bench for rob_buffer: allocation up to full, in-order retirement
// with out-of-order completion, pointer wrap, lookup bypass, flush and
// asynchronous reset. One line per checked transaction on mismatch.
// ---------------------------------------------------------------------------
module tb_rob_buffer;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [2:0]  alloc_idx;
  logic        cdb_valid;
  logic [2:0]  cdb_idx;
  logic [15:0] cdb_value;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [15:0] commit_value;
  logic        commit_ready;
  logic        flush;
  logic [2:0]  src1_idx;
  logic        src1_done;
  logic [15:0] src1_value;
  logic [2:0]  src2_idx;
  logic        src2_done;
  logic [15:0] src2_value;
  logic [3:0]  count;
  logic        empty;
  logic        full;

  int total = 0;
  int bad   = 0;

  rob_buffer dut (
    .clk1         (clk1),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_rd     (alloc_rd),
    .alloc_ready  (alloc_ready),
    .alloc_idx    (alloc_idx),
    .cdb_valid    (cdb_valid),
    .cdb_idx      (cdb_idx),
    .cdb_value    (cdb_value),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_value (commit_value),
    .commit_ready (commit_ready),
    .flush        (flush),
    .src1_idx     (src1_idx),
    .src1_done    (src1_done),
    .src1_value   (src1_value),
    .src2_idx     (src2_idx),
    .src2_done    (src2_done),
    .src2_value   (src2_value),
    .count        (count),
    .empty        (empty),
    .full         (full)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are then changed 1 time unit after the edge.
  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle();
    alloc_valid  = 1'b0;
    cdb_valid    = 1'b0;
    commit_ready = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    alloc_rd = '0; cdb_idx = '0; cdb_value = '0;
    src1_idx = '0; src2_idx = '0;
    #2;
    chk("rst_alloc_ready", 32'(alloc_ready), 1);
    chk("rst_alloc_idx", 32'(alloc_idx), 0);
    chk("rst_commit_valid", 32'(commit_valid), 0);
    chk("rst_commit_rd", 32'(commit_rd), 0);
    chk("rst_commit_value", 32'(commit_value), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_src1_done", 32'(src1_done), 0);
    chk("rst_src2_done", 32'(src2_done), 0);
    rst = 1'b0;
    step();

    // Fill all eight entries, then try a ninth.
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1;
      alloc_rd    = 5'(i + 1);
      #1;
      chk("fill_alloc_idx", 32'(alloc_idx), 32'(i));
      step();
    end
    chk("fill_count", 32'(count), 8);
    chk("fill_full", 32'(full), 1);
    chk("fill_alloc_ready", 32'(alloc_ready), 0);
    alloc_rd = 5'd9;
    step();
    chk("over_count", 32'(count), 8);
    chk("over_commit_valid", 32'(commit_valid), 0);
    do_flush();
    chk("flush1_count", 32'(count), 0);

    // Single instruction: alloc, CDB, commit.
    alloc_valid = 1'b1; alloc_rd = 5'd3;
    #1;
    chk("single_tag", 32'(alloc_idx), 0);
    step();
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_idx = 3'd0; cdb_value = 16'h00AB;
    #1;
    chk("single_cv_same_cycle", 32'(commit_valid), 0);
    step();
    cdb_valid = 1'b0;
    chk("single_cv", 32'(commit_valid), 1);
    chk("single_rd", 32'(commit_rd), 3);
    chk("single_value", 32'(commit_value), 32'h00AB);
    commit_ready = 1'b1;
    step();
    commit_ready = 1'b0;
    chk("single_count", 32'(count), 0);
    chk("single_empty", 32'(empty), 1);
    do_flush();

    // Out-of-order completion, in-order retirement.
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(10 + i);
      step();
    end
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_idx = 3'd2; cdb_value = 16'h2222;
    step();
    chk("ooo_cv_after2", 32'(commit_valid), 0);
    cdb_idx = 3'd1; cdb_value = 16'h1111;
    step();
    chk("ooo_cv_after1", 32'(commit_valid), 0);
    cdb_idx = 3'd0; cdb_value = 16'h0000;
    step();
    cdb_valid = 1'b0;
    chk("ooo_c0_valid", 32'(commit_valid), 1);
    chk("ooo_c0_rd", 32'(commit_rd), 10);
    chk("ooo_c0_value", 32'(commit_value), 0);
    commit_ready = 1'b1;
    step();
    chk("ooo_c1_rd", 32'(commit_rd), 11);
    chk("ooo_c1_value", 32'(commit_value), 32'h1111);
    step();
    chk("ooo_c2_rd", 32'(commit_rd), 12);
    chk("ooo_c2_value", 32'(commit_value), 32'h2222);
    step();
    commit_ready = 1'b0;
    chk("ooo_done_cv", 32'(commit_valid), 0);
    chk("ooo_done_empty", 32'(empty), 1);
    do_flush();

    // Wrap-around: six complete lifetimes, then four allocations.
    for (int i = 0; i < 6; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'd1;
      #1;
      chk("wrap_pair_tag", 32'(alloc_idx), 32'(i));
      step();
      alloc_valid = 1'b0;
      cdb_valid = 1'b1; cdb_idx = 3'(i); cdb_value = 16'(i);
      step();
      cdb_valid = 1'b0;
      commit_ready = 1'b1;
      step();
      commit_ready = 1'b0;
    end
    chk("wrap_empty", 32'(count), 0);
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(20 + i);
      #1;
      chk("wrap_tag", 32'(alloc_idx), 32'((6 + i) % 8));
      step();
    end
    alloc_valid = 1'b0;
    chk("wrap_count", 32'(count), 4);
    chk("wrap_tail", 32'(alloc_idx), 2);
    cdb_valid = 1'b1; cdb_idx = 3'd6; cdb_value = 16'h6666;
    step();
    cdb_valid = 1'b0;
    chk("wrap_head_cv", 32'(commit_valid), 1);
    chk("wrap_head_rd", 32'(commit_rd), 20);
    chk("wrap_head_value", 32'(commit_value), 32'h6666);
    // Simultaneous alloc and commit leave count unchanged.
    alloc_valid = 1'b1; alloc_rd = 5'd24; commit_ready = 1'b1;
    step();
    idle();
    chk("ac_count", 32'(count), 4);
    chk("ac_tail", 32'(alloc_idx), 3);
    chk("ac_cv", 32'(commit_valid), 0);

    // Lookup bypass: tag 1 busy, not done.
    src1_idx = 3'd1; src2_idx = 3'd0;
    cdb_valid = 1'b1; cdb_idx = 3'd1; cdb_value = 16'h0F0F;
    #1;
    chk("byp_src1_done", 32'(src1_done), 1);
    chk("byp_src1_value", 32'(src1_value), 32'h0F0F);
    chk("byp_src2_done", 32'(src2_done), 0);
    step();
    cdb_valid = 1'b0;
    #1;
    chk("stored_src1_done", 32'(src1_done), 1);
    chk("stored_src1_value", 32'(src1_value), 32'h0F0F);
    // Broadcast to a free entry is neither forwarded nor stored.
    src2_idx = 3'd5;
    cdb_valid = 1'b1; cdb_idx = 3'd5; cdb_value = 16'h5555;
    #1;
    chk("free_src2_done", 32'(src2_done), 0);
    chk("free_src2_value", 32'(src2_value), 0);
    step();
    cdb_valid = 1'b0;
    #1;
    chk("free_after_done", 32'(src2_done), 0);
    do_flush();

    // Flush with five entries, two done, commit offered.
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(i);
      step();
    end
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_idx = 3'd0; cdb_value = 16'hAAAA;
    step();
    cdb_idx = 3'd1; cdb_value = 16'hBBBB;
    step();
    cdb_valid = 1'b0;
    chk("pre_flush_count", 32'(count), 5);
    chk("pre_flush_cv", 32'(commit_valid), 1);
    flush = 1'b1; commit_ready = 1'b1; alloc_valid = 1'b1;
    cdb_valid = 1'b1; cdb_idx = 3'd2;
    step();
    idle();
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_alloc_idx", 32'(alloc_idx), 0);
    chk("flush_cv", 32'(commit_valid), 0);

    // Asynchronous reset between edges.
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    step();
    step();
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_idx = 3'd0; cdb_value = 16'h1234;
    step();
    cdb_valid = 1'b0;
    chk("pre_rst_cv", 32'(commit_valid), 1);
    chk("pre_rst_count", 32'(count), 2);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_cv", 32'(commit_valid), 0);
    chk("arst_value", 32'(commit_value), 0);
    chk("arst_alloc_idx", 32'(alloc_idx), 0);
    chk("arst_empty", 32'(empty), 1);
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
